// File: rtl/picobello_mcast_unroller.sv
// Expands one multicast request (address + X/Y mask) into the ordered sequence of unicast
// cluster addresses it covers, emitting one beat per output handshake.
module picobello_mcast_unroller #(
   parameter int unsigned AddrWidth = 48,
   parameter int unsigned OffsetY   = 18,
   parameter int unsigned LenY      = 2,
   parameter int unsigned OffsetX   = 20,
   parameter int unsigned LenX      = 2
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 in_valid_i,
   output logic                 in_ready_o,
   input  logic [AddrWidth-1:0] in_addr_i,
   input  logic [AddrWidth-1:0] in_mask_i,
   output logic                 out_valid_o,
   input  logic                 out_ready_i,
   output logic [AddrWidth-1:0] out_addr_o,
   output logic [LenX-1:0]      out_x_o,
   output logic [LenY-1:0]      out_y_o,
   output logic                 out_last_o,
   output logic                 out_err_o
);

   // Handshakes: a transfer happens on a rising edge where valid && ready; valid never
   // depends on ready, and the request side (in_ready_o) depends on the FSM state only.

   typedef enum logic {
      IDLE = 1'b0,
      EMIT = 1'b1
   } state_e;

   localparam logic [AddrWidth-1:0] XField = {{(AddrWidth-LenX){1'b0}}, {LenX{1'b1}}} << OffsetX;
   localparam logic [AddrWidth-1:0] YField = {{(AddrWidth-LenY){1'b0}}, {LenY{1'b1}}} << OffsetY;
   localparam logic [AddrWidth-1:0] XyField = XField | YField;

   state_e                 state, state_next;
   logic [AddrWidth-1:0]   base;
   logic [LenX-1:0]        mx, xs;
   logic [LenY-1:0]        my, ys;
   logic                   err;
   logic                   in_fire, out_fire, last_beat;

   // Next submask of m above s, wrapping to 0 after s == m.
   function automatic logic [LenX-1:0] next_sub_x(input logic [LenX-1:0] s, input logic [LenX-1:0] m);
      logic [LenX-1:0] t;
      t = (s | ~m) + LenX'(1);
      return t & m;
   endfunction

   function automatic logic [LenY-1:0] next_sub_y(input logic [LenY-1:0] s, input logic [LenY-1:0] m);
      logic [LenY-1:0] t;
      t = (s | ~m) + LenY'(1);
      return t & m;
   endfunction

   assign in_fire   = in_valid_i && (state == IDLE);
   assign out_fire  = out_ready_i && (state == EMIT);
   assign last_beat = (xs == mx) && (ys == my);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state <= IDLE;
      else         state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (in_fire) state_next = EMIT;
         EMIT: if (out_fire && last_beat) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         base <= '0;
         mx   <= '0;
         my   <= '0;
         xs   <= '0;
         ys   <= '0;
         err  <= 1'b0;
      end else if (in_fire) begin
         base <= in_addr_i & ~(in_mask_i & XyField);
         mx   <= in_mask_i[OffsetX +: LenX];
         my   <= in_mask_i[OffsetY +: LenY];
         xs   <= '0;
         ys   <= '0;
         err  <= |(in_mask_i & ~XyField);
      end else if (out_fire) begin
         // Y is the inner loop; X advances when Y has covered its whole mask.
         if (ys != my) begin
            ys <= next_sub_y(ys, my);
         end else begin
            ys <= '0;
            xs <= next_sub_x(xs, mx);
         end
      end
   end

   assign in_ready_o  = (state == IDLE);
   assign out_valid_o = (state == EMIT);
   assign out_addr_o  = base | (AddrWidth'(xs) << OffsetX) | (AddrWidth'(ys) << OffsetY);
   assign out_x_o     = out_addr_o[OffsetX +: LenX];
   assign out_y_o     = out_addr_o[OffsetY +: LenY];
   assign out_last_o  = (state == EMIT) && last_beat;
   assign out_err_o   = (state == EMIT) && err;

endmodule

// File: tb/tb_picobello_mcast_unroller.sv
// Bench for picobello_mcast_unroller: directed and random requests checked beat by beat
// against a list of expected unicast addresses built from the mask rules.
module tb_picobello_mcast_unroller;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        in_valid_i = 1'b0;
   logic        in_ready_o;
   logic [47:0] in_addr_i = '0;
   logic [47:0] in_mask_i = '0;
   logic        out_valid_o;
   logic        out_ready_i = 1'b0;
   logic [47:0] out_addr_o;
   logic [1:0]  out_x_o;
   logic [1:0]  out_y_o;
   logic        out_last_o;
   logic        out_err_o;

   int tests = 0;
   int failed = 0;

   // {err, last, addr}
   logic [49:0] exp_q[$];

   always #5 clk_i = ~clk_i;

   picobello_mcast_unroller dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
      .in_addr_i(in_addr_i), .in_mask_i(in_mask_i),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
      .out_addr_o(out_addr_o), .out_x_o(out_x_o), .out_y_o(out_y_o),
      .out_last_o(out_last_o), .out_err_o(out_err_o)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: every (x, y) pair whose bits lie inside the mask, in ascending order,
   // Y varying fastest; the final pair carries last.
   task automatic build_model(input logic [47:0] addr, input logic [47:0] mask);
      logic [47:0] xy, base;
      logic [1:0]  mx, my;
      logic        err;
      xy   = 48'h3C_0000;
      base = addr & ~(mask & xy);
      mx   = mask[21:20];
      my   = mask[19:18];
      err  = |(mask & ~xy);
      exp_q.delete();
      for (int x = 0; x < 4; x++) begin
         if ((x & ~int'(mx)) != 0) continue;
         for (int y = 0; y < 4; y++) begin
            if ((y & ~int'(my)) != 0) continue;
            exp_q.push_back({err, 1'b0, base | (48'(x) << 20) | (48'(y) << 18)});
         end
      end
      exp_q[exp_q.size()-1][48] = 1'b1;
   endtask

   // mode 0: always ready; 1: random ready; 2: ready low 3 cycles while beat index 4 shows.
   // abort_at >= 0 pulses reset while that beat index is on the output.
   task automatic run_req(input logic [47:0] addr, input logic [47:0] mask,
                          input int mode, input int abort_at);
      int idx, stall, cyc;
      logic [49:0] e;
      logic r;
      idx = 0; stall = 0; cyc = 0;
      build_model(addr, mask);
      @(negedge clk_i);
      check("in_ready_idle", 64'(in_ready_o), 64'd1);
      in_valid_i = 1'b1;
      in_addr_i  = addr;
      in_mask_i  = mask;
      @(negedge clk_i);
      in_valid_i = 1'b0;
      in_addr_i  = {16'($urandom), 32'($urandom)};
      in_mask_i  = {16'($urandom), 32'($urandom)};
      while (exp_q.size() > 0 && cyc < 200) begin
         e = exp_q[0];
         check("out_valid", 64'(out_valid_o), 64'd1);
         check("in_ready_busy", 64'(in_ready_o), 64'd0);
         check("out_addr", 64'(out_addr_o), 64'(e[47:0]));
         check("out_x", 64'(out_x_o), 64'(e[21:20]));
         check("out_y", 64'(out_y_o), 64'(e[19:18]));
         check("out_last", 64'(out_last_o), 64'(e[48]));
         check("out_err", 64'(out_err_o), 64'(e[49]));
         if (abort_at >= 0 && idx == abort_at) begin
            rst_ni = 1'b0;
            #1;
            check("rst_valid", 64'(out_valid_o), 64'd0);
            check("rst_ready", 64'(in_ready_o), 64'd1);
            check("rst_addr", 64'(out_addr_o), 64'd0);
            check("rst_last", 64'(out_last_o), 64'd0);
            out_ready_i = 1'b0;
            @(negedge clk_i);
            rst_ni = 1'b1;
            exp_q.delete();
            return;
         end
         if (mode == 0) r = 1'b1;
         else if (mode == 1) r = 1'($urandom_range(0, 1));
         else if (idx == 4 && stall < 3) begin
            r = 1'b0;
            stall++;
         end else r = 1'b1;
         out_ready_i = r;
         @(negedge clk_i);
         if (r) begin
            void'(exp_q.pop_front());
            idx++;
         end
         cyc++;
      end
      check("beats_outstanding", 64'(exp_q.size()), 64'd0);
      out_ready_i = 1'b0;
      check("done_valid", 64'(out_valid_o), 64'd0);
      check("done_ready", 64'(in_ready_o), 64'd1);
   endtask

   initial begin
      logic [47:0] a, m;
      repeat (3) @(negedge clk_i);
      check("reset_ready", 64'(in_ready_o), 64'd1);
      check("reset_valid", 64'(out_valid_o), 64'd0);
      check("reset_addr", 64'(out_addr_o), 64'd0);
      check("reset_xy", 64'({out_x_o, out_y_o}), 64'd0);
      check("reset_last", 64'(out_last_o), 64'd0);
      check("reset_err", 64'(out_err_o), 64'd0);
      rst_ni = 1'b1;

      run_req(48'h0000_1234, 48'h0, 0, -1);
      run_req(48'h0000_1234, 48'h0030_0000, 0, -1);
      run_req(48'h0010_0000, 48'h0014_0000, 1, -1);
      run_req(48'h0000_0000, 48'h003C_0000, 0, -1);
      run_req(48'h0000_0000, 48'h003C_0000, 2, -1);
      run_req(48'h0000_1234, 48'h0000_0100, 0, -1);
      run_req(48'h0000_1234, 48'h0004_0100, 1, -1);
      run_req(48'h0000_1234, 48'h0030_0000, 0, 2);
      run_req(48'h0000_5678, 48'h0, 0, -1);

      for (int i = 0; i < 25; i++) begin
         a = {16'($urandom), 32'($urandom)};
         m = {16'($urandom), 32'($urandom)} & 48'h3C_0000;
         if ($urandom_range(0, 3) == 0) m = m | (48'h1 << $urandom_range(0, 47));
         run_req(a, m, $urandom_range(0, 1), -1);
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
